vec_exec_unit: RTL

Lane-parallel vector execution stage between operand read (register-file `rd1`/`rd2`) and writeback (register-file `wd3`/`ra3`/`we3`/`selec_v_s_w`). Single-cycle element-wise ALU ops take one cycle. Multi-cycle cross-lane reductions (sum, signed max) go through a 4-level pairwise tree. Valid/ready handshakes on both sides; one registered result slot drives the writeback port directly.

---
 rtl/vec_exec_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vec_exec_unit.sv
// Lane-parallel vector execution stage: one-cycle element-wise ALU ops and a
// 4-level pairwise reduction tree (sum, signed max) feeding a single result slot.
module vec_exec_unit #(
   parameter int LANES = 16,
   parameter int W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [LANES*W-1:0] rd1,
   input  logic [LANES*W-1:0] rd2,
   input  logic [3:0]         dst,
   input  logic               vec_dst,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] wd3,
   output logic [3:0]         ra3,
   output logic               selec_v_s_w,
   output logic               we3,
   output logic               busy,
   output logic               dbg_state_o
);

   // Handshake: a bundle moves on an edge where in_valid & in_ready; a result
   // moves on an edge where out_valid & out_ready; neither side may retract.

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RED  = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               level_q, level_d;
   logic [LANES-1:0][W-1:0]  work_q, work_d;
   logic                     red_max_q, red_max_d;
   logic [3:0]               red_dst_q, red_dst_d;
   logic                     red_vdst_q, red_vdst_d;
   logic                     out_valid_q, out_valid_d;
   logic [LANES*W-1:0]       wd3_q, wd3_d;
   logic [3:0]               ra3_q, ra3_d;
   logic                     sel_q, sel_d;
   logic                     nop_q, nop_d;

   logic                     slot_free;
   logic                     accept;
   logic [LANES*W-1:0]       elem_res;
   logic [LANES-1:0][W-1:0]  pair_res;

   assign slot_free   = ~out_valid_q | out_ready;
   assign in_ready    = (state_q == S_IDLE) & slot_free;
   assign accept      = in_valid & in_ready;
   assign out_valid   = out_valid_q;
   assign wd3         = wd3_q;
   assign ra3         = ra3_q;
   assign selec_v_s_w = sel_q;
   assign we3         = out_valid_q & out_ready & ~nop_q;
   assign busy        = (state_q == S_RED);
   assign dbg_state_o = state_q;

   always_comb begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      elem_res = '0;
      a        = '0;
      b        = '0;
      for (int i = 0; i < LANES; i++) begin
         a = rd1[i*W +: W];
         b = rd2[i*W +: W];
         case (op)
            4'd0:    elem_res[i*W +: W] = a + b;
            4'd1:    elem_res[i*W +: W] = a - b;
            4'd2:    elem_res[i*W +: W] = a * b;
            4'd3:    elem_res[i*W +: W] = a & b;
            4'd4:    elem_res[i*W +: W] = a | b;
            4'd5:    elem_res[i*W +: W] = a ^ b;
            4'd6:    elem_res[i*W +: W] = a << b[4:0];
            4'd7:    elem_res[i*W +: W] = a >> b[4:0];
            4'd8:    elem_res[i*W +: W] = unsigned'($signed(a) >>> b[4:0]);
            default: elem_res[i*W +: W] = '0;
         endcase
      end
   end

   // One tree level: lane k takes the combination of lanes 2k and 2k+1.
   always_comb begin
      pair_res = '0;
      for (int k = 0; k < LANES/2; k++) begin
         if (red_max_q)
            pair_res[k] = ($signed(work_q[2*k]) > $signed(work_q[2*k+1])) ?
                          work_q[2*k] : work_q[2*k+1];
         else
            pair_res[k] = work_q[2*k] + work_q[2*k+1];
      end
   end

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      work_d      = work_q;
      red_max_d   = red_max_q;
      red_dst_d   = red_dst_q;
      red_vdst_d  = red_vdst_q;
      out_valid_d = out_valid_q & ~out_ready;
      wd3_d       = wd3_q;
      ra3_d       = ra3_q;
      sel_d       = sel_q;
      nop_d       = nop_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == 4'd9 || op == 4'd10) begin
                  work_d     = rd1;
                  level_d    = 3'd0;
                  red_max_d  = (op == 4'd10);
                  red_dst_d  = dst;
                  red_vdst_d = vec_dst;
                  state_d    = S_RED;
               end else begin
                  out_valid_d = 1'b1;
                  wd3_d       = elem_res;
                  ra3_d       = dst;
                  sel_d       = vec_dst;
                  nop_d       = (op > 4'd8);
               end
            end
         end
         S_RED: begin
            // Final level writes straight into the slot when it is free;
            // otherwise the scalar is parked in lane 0 at level 4.
            if (level_q == 3'd4 || level_q == 3'd3) begin
               if (slot_free) begin
                  out_valid_d = 1'b1;
                  wd3_d       = '0;
                  wd3_d[(LANES-1)*W +: W] = (level_q == 3'd4) ? work_q[0] : pair_res[0];
                  ra3_d       = red_dst_q;
                  sel_d       = red_vdst_q;
                  nop_d       = 1'b0;
                  level_d     = 3'd0;
                  state_d     = S_IDLE;
               end else if (level_q == 3'd3) begin
                  work_d  = pair_res;
                  level_d = 3'd4;
               end
            end else begin
               work_d  = pair_res;
               level_d = level_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q     <= '0;
         work_q      <= '0;
         red_max_q   <= 1'b0;
         red_dst_q   <= '0;
         red_vdst_q  <= 1'b0;
         out_valid_q <= 1'b0;
         wd3_q       <= '0;
         ra3_q       <= '0;
         sel_q       <= 1'b0;
         nop_q       <= 1'b0;
      end else begin
         level_q     <= level_d;
         work_q      <= work_d;
         red_max_q   <= red_max_d;
         red_dst_q   <= red_dst_d;
         red_vdst_q  <= red_vdst_d;
         out_valid_q <= out_valid_d;
         wd3_q       <= wd3_d;
         ra3_q       <= ra3_d;
         sel_q       <= sel_d;
         nop_q       <= nop_d;
      end
   end

endmodule
